gemm_result_streamer: RTL and testbench

GEMM_RESULT_STREAMER -- requirements
Module: gemm_result_streamer

---
 rtl/gemm_pkg.sv | 20 ++
 rtl/gemm_rowcol_counter.sv | 45 ++++
 rtl/gemm_result_streamer.sv | 112 +++++++++++
 tb/tb_gemm_result_streamer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared GEMM definitions: default matrix geometry, element width and the
// handshake state encoding used by the GEMM core and its result streamer.
package gemm_pkg;

  localparam int GEMM_DATA_WIDTH    = 64;
  localparam int GEMM_MATRIX_HEIGHT = 4;
  localparam int GEMM_MATRIX_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2
  } gemm_state_e;

  // Index width for a dimension; a degenerate dimension of 1 still gets 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gemm_rowcol_counter.sv
// Row-major index generator: computes the next (row, col) for a transfer and
// flags the final element. Purely combinational; the owner holds the registers.
module gemm_rowcol_counter
  import gemm_pkg::*;
#(
  parameter int HEIGHT = GEMM_MATRIX_HEIGHT,
  parameter int WIDTH  = GEMM_MATRIX_WIDTH,
  localparam int RW = idx_width(HEIGHT),
  localparam int CW = idx_width(WIDTH)
) (
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic          advance,
  output logic [RW-1:0] row_next,
  output logic [CW-1:0] col_next,
  output logic          wrap,
  output logic          last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);

  logic col_end;
  logic row_end;

  assign col_end = (col == COL_MAX);
  assign row_end = (row == ROW_MAX);
  assign last    = col_end && row_end;
  // Whole-matrix wrap: the final element is being consumed.
  assign wrap    = advance && last;

  always_comb begin
    row_next = row;
    col_next = col;
    if (advance) begin
      if (col_end) begin
        col_next = '0;
        row_next = row_end ? '0 : row + 1'b1;
      end else begin
        col_next = col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gemm_result_streamer.sv
// Captures a finished GEMM result matrix and streams it out element by element
// in row-major order over a valid/ready interface.
module gemm_result_streamer
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH    = GEMM_DATA_WIDTH,
  parameter int MATRIX_HEIGHT = GEMM_MATRIX_HEIGHT,
  parameter int MATRIX_WIDTH  = GEMM_MATRIX_WIDTH,
  localparam int RW = idx_width(MATRIX_HEIGHT),
  localparam int CW = idx_width(MATRIX_WIDTH)
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic [DATA_WIDTH-1:0] iresult_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
  input  logic                  idone,
  input  logic                  iready,
  output logic                  ovalid,
  output logic [DATA_WIDTH-1:0] odata,
  output logic [RW-1:0]         orow,
  output logic [CW-1:0]         ocol,
  output logic                  olast,
  output logic                  obusy,
  output logic                  odone,
  output logic                  ooverrun
);

  gemm_state_e           state_reg;
  logic [RW-1:0]         row_reg;
  logic [CW-1:0]         col_reg;
  logic                  odone_reg;
  logic                  ooverrun_reg;
  logic [DATA_WIDTH-1:0] buf_reg [MATRIX_HEIGHT][MATRIX_WIDTH];

  logic [RW-1:0] row_next;
  logic [CW-1:0] col_next;
  logic          cnt_wrap;
  logic          cnt_last;
  logic          xfer;

  assign xfer = (state_reg == STREAM) && iready;

  gemm_rowcol_counter #(
    .HEIGHT (MATRIX_HEIGHT),
    .WIDTH  (MATRIX_WIDTH)
  ) u_rowcol (
    .row      (row_reg),
    .col      (col_reg),
    .advance  (xfer),
    .row_next (row_next),
    .col_next (col_next),
    .wrap     (cnt_wrap),
    .last     (cnt_last)
  );

  // Buffer is data-only: no reset, written once per accepted run.
  always_ff @(posedge iclk) begin
    if (state_reg == CAPTURE) begin
      buf_reg <= iresult_matrix;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_reg    <= IDLE;
      row_reg      <= '0;
      col_reg      <= '0;
      odone_reg    <= 1'b0;
      ooverrun_reg <= 1'b0;
    end else begin
      odone_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (idone) begin
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          row_reg   <= '0;
          col_reg   <= '0;
          state_reg <= STREAM;
          if (idone) begin
            ooverrun_reg <= 1'b1;
          end
        end
        STREAM: begin
          row_reg <= row_next;
          col_reg <= col_next;
          // A new run arriving with the final transfer is accepted, not dropped.
          if (cnt_wrap) begin
            odone_reg <= 1'b1;
            state_reg <= idone ? CAPTURE : IDLE;
          end else if (idone) begin
            ooverrun_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ovalid   = (state_reg == STREAM);
  assign obusy    = (state_reg != IDLE);
  assign olast    = ovalid && cnt_last;
  assign odata    = buf_reg[row_reg][col_reg];
  assign orow     = row_reg;
  assign ocol     = col_reg;
  assign odone    = odone_reg;
  assign ooverrun = ooverrun_reg;

endmodule

// File: tb/tb_gemm_result_streamer.sv
// Directed bench for gemm_result_streamer: basic stream, backpressure,
// back-to-back runs, overrun, mid-stream reset and extreme data values.
module tb_gemm_result_streamer;

  logic        iclk;
  logic        irst;
  logic [63:0] mat [4][4];
  logic        idone;
  logic        iready;
  logic        ovalid;
  logic [63:0] odata;
  logic [1:0]  orow;
  logic [1:0]  ocol;
  logic        olast;
  logic        obusy;
  logic        odone;
  logic        ooverrun;

  logic [63:0] exp_mat [4][4];
  int n_tests = 0;
  int n_fail  = 0;

  gemm_result_streamer #(
    .DATA_WIDTH    (64),
    .MATRIX_HEIGHT (4),
    .MATRIX_WIDTH  (4)
  ) dut (
    .iclk           (iclk),
    .irst           (irst),
    .iresult_matrix (mat),
    .idone          (idone),
    .iready         (iready),
    .ovalid         (ovalid),
    .odata          (odata),
    .orow           (orow),
    .ocol           (ocol),
    .olast          (olast),
    .obusy          (obusy),
    .odone          (odone),
    .ooverrun       (ooverrun)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  // 0: 16*i+j   1: second-run marker   2: high-bit pattern   3: extreme values
  task automatic fill(input int kind);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        case (kind)
          0: mat[i][j] = 64'(16 * i + j);
          1: mat[i][j] = 64'hA5A5_0000_0000_0000 | 64'(16 * i + j);
          2: mat[i][j] = 64'hFEDC_BA98_7654_0000 + 64'(16 * i + j);
          default: mat[i][j] = ((i + j) % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                  : 64'h8000_0000_0000_0000;
        endcase
      end
    end
  endtask

  task automatic kick();
    idone = 1'b1;
    step();
    idone = 1'b0;
    check("capture_valid", 64'(ovalid), 64'd0);
    check("capture_busy", 64'(obusy), 64'd1);
    step();
    check("first_valid", 64'(ovalid), 64'd1);
  endtask

  // mode 0: iready always 1; mode 1: iready 1,0,0,1,0,0...
  task automatic stream(input int mode, input int ovr_at, input int rst_at, input bit b2b);
    int  idx = 0;
    int  cyc = 0;
    int  r;
    int  c;
    bit  xfer;
    bit  ovr_done = 1'b0;
    bit  ovr_chk = 1'b0;
    while (idx < 16 && cyc < 100) begin
      r = idx / 4;
      c = idx % 4;
      check("valid", 64'(ovalid), 64'd1);
      check("data", odata, exp_mat[r][c]);
      check("row", 64'(orow), 64'(r));
      check("col", 64'(ocol), 64'(c));
      check("last", 64'(olast), 64'(idx == 15));
      if (idx == rst_at) begin
        irst   = 1'b1;
        iready = 1'b1;
        step();
        irst = 1'b0;
        $display("[TB] reset at element %0d", idx);
        check("rst_valid", 64'(ovalid), 64'd0);
        check("rst_busy", 64'(obusy), 64'd0);
        check("rst_done", 64'(odone), 64'd0);
        check("rst_overrun", 64'(ooverrun), 64'd0);
        step();
        check("rst_no_done", 64'(odone), 64'd0);
        return;
      end
      iready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (idx == ovr_at && !ovr_done) begin
        idone = 1'b1;
        fill(1);
        ovr_done = 1'b1;
      end
      if (b2b && idx == 15 && iready) begin
        idone = 1'b1;
        fill(1);
      end
      xfer = iready;
      step();
      cyc++;
      idone = 1'b0;
      if (xfer) begin
        $display("[TB] xfer row=%0d col=%0d data=%h", r, c, exp_mat[r][c]);
        idx++;
      end
      if (ovr_done && !ovr_chk) begin
        check("overrun_set", 64'(ooverrun), 64'd1);
        ovr_chk = 1'b1;
      end
    end
    if (idx < 16) begin
      check("timeout", 64'(idx), 64'd16);
      return;
    end
    if (mode == 0) check("consecutive", 64'(cyc), 64'd16);
    check("end_done", 64'(odone), 64'd1);
    check("end_valid", 64'(ovalid), 64'd0);
    check("end_busy", 64'(obusy), 64'(b2b));
    if (!b2b) begin
      step();
      check("done_pulse", 64'(odone), 64'd0);
    end
  endtask

  initial begin
    irst   = 1'b1;
    idone  = 1'b0;
    iready = 1'b0;
    fill(0);
    step();
    step();
    check("reset_valid", 64'(ovalid), 64'd0);
    check("reset_busy", 64'(obusy), 64'd0);
    check("reset_done", 64'(odone), 64'd0);
    check("reset_overrun", 64'(ooverrun), 64'd0);
    check("reset_last", 64'(olast), 64'd0);
    irst = 1'b0;
    step();
    check("idle_valid", 64'(ovalid), 64'd0);

    // Basic: 0x00..0x33, no stalls
    fill(0);
    exp_mat = mat;
    kick();
    stream(0, -1, -1, 1'b0);

    // Backpressure
    fill(2);
    exp_mat = mat;
    kick();
    stream(1, -1, -1, 1'b0);

    // Back-to-back: second idone on the final transfer
    fill(0);
    exp_mat = mat;
    kick();
    stream(0, -1, -1, 1'b1);
    exp_mat = mat;
    step();
    check("b2b_valid", 64'(ovalid), 64'd1);
    check("b2b_done_clear", 64'(odone), 64'd0);
    stream(0, -1, -1, 1'b0);
    check("b2b_overrun", 64'(ooverrun), 64'd0);

    // Overrun at element 5 under backpressure
    fill(2);
    exp_mat = mat;
    kick();
    stream(1, 5, -1, 1'b0);
    check("overrun_sticky", 64'(ooverrun), 64'd1);
    step();
    check("overrun_persist", 64'(ooverrun), 64'd1);
    check("overrun_idle", 64'(obusy), 64'd0);

    // Reset at element 7, then restart from [0][0] with extreme data
    fill(0);
    exp_mat = mat;
    kick();
    stream(0, -1, 7, 1'b0);
    fill(3);
    exp_mat = mat;
    kick();
    check("restart_row", 64'(orow), 64'd0);
    check("restart_col", 64'(ocol), 64'd0);
    check("neg_first", odata, 64'hFFFF_FFFF_FFFF_FFFF);
    stream(0, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
